// File: rtl/mpeg_vlc_pkg.sv
// Types and constants shared by the MPEG-1 VLC encoder and its code table.
// DCT_COEFF_ENCODER_ESCAPE_EN sizes the shift register for 28-bit escape codes.
package mpeg_vlc_pkg;

  typedef struct packed {
    logic              codetable;
    logic              first;
    logic              eob;
    logic [5:0]        run;
    logic signed [8:0] level;
  } vlc_symbol_t;

  // DCT entries carry a zero sign slot in code[0] and count it in len.
  typedef struct packed {
    logic [16:0] code;
    logic [4:0]  len;
    logic        hit;
  } vlc_codeword_t;

  localparam logic [5:0] ESC_PREFIX     = 6'b000001;
  localparam int         ESC_SHORT_LEN  = 20;
  localparam int         ESC_LONG_LEN   = 28;
  localparam logic [1:0] EOB_CODE       = 2'b10;
  localparam int         EOB_LEN        = 2;

`ifdef DCT_COEFF_ENCODER_ESCAPE_EN
  localparam int SR_W = 28;
`else
  localparam int SR_W = 17;
`endif

  function automatic logic [8:0] level_mag(input logic [8:0] level);
    return level[8] ? (~level + 9'd1) : level;
  endfunction

endpackage

// File: rtl/dct_coeff_vlc_table.sv
// Combinational {run,|level|} / increment -> codeword lookup; inverse of the
// decoder trees for the DCT coefficient and macroblock address increment tables.
module dct_coeff_vlc_table
  import mpeg_vlc_pkg::*;
(
  input  logic          codetable,
  input  logic [15:0]   key,
  output vlc_codeword_t cw
);

  logic [20:0] e;  // {len, code right-aligned}

  always_comb begin
    e = '0;
    if (codetable) begin
      case (key[7:0])
        8'd1:  e = {5'd1,  16'b1};
        8'd2:  e = {5'd3,  16'b011};
        8'd3:  e = {5'd3,  16'b010};
        8'd4:  e = {5'd4,  16'b0011};
        8'd5:  e = {5'd4,  16'b0010};
        8'd6:  e = {5'd5,  16'b00011};
        8'd7:  e = {5'd5,  16'b00010};
        8'd8:  e = {5'd7,  16'b0000111};
        8'd9:  e = {5'd7,  16'b0000110};
        8'd10: e = {5'd8,  16'b00001011};
        8'd11: e = {5'd8,  16'b00001010};
        8'd12: e = {5'd8,  16'b00001001};
        8'd13: e = {5'd8,  16'b00001000};
        8'd14: e = {5'd8,  16'b00000111};
        8'd15: e = {5'd8,  16'b00000110};
        8'd16: e = {5'd10, 16'b0000010111};
        8'd17: e = {5'd10, 16'b0000010110};
        8'd18: e = {5'd10, 16'b0000010101};
        8'd19: e = {5'd10, 16'b0000010100};
        8'd20: e = {5'd10, 16'b0000010011};
        8'd21: e = {5'd10, 16'b0000010010};
        8'd22: e = {5'd11, 16'b00000100011};
        8'd23: e = {5'd11, 16'b00000100010};
        8'd24: e = {5'd11, 16'b00000100001};
        8'd25: e = {5'd11, 16'b00000100000};
        8'd26: e = {5'd11, 16'b00000011111};
        8'd27: e = {5'd11, 16'b00000011110};
        8'd28: e = {5'd11, 16'b00000011101};
        8'd29: e = {5'd11, 16'b00000011100};
        8'd30: e = {5'd11, 16'b00000011011};
        8'd31: e = {5'd11, 16'b00000011010};
        8'd32: e = {5'd11, 16'b00000011001};
        8'd33: e = {5'd11, 16'b00000011000};
        default: e = '0;
      endcase
    end else begin
      case (key)
        {8'd0,  8'd1}:  e = {5'd2,  16'b11};
        {8'd1,  8'd1}:  e = {5'd3,  16'b011};
        {8'd0,  8'd2}:  e = {5'd4,  16'b0100};
        {8'd2,  8'd1}:  e = {5'd4,  16'b0101};
        {8'd0,  8'd3}:  e = {5'd5,  16'b00101};
        {8'd3,  8'd1}:  e = {5'd5,  16'b00111};
        {8'd4,  8'd1}:  e = {5'd5,  16'b00110};
        {8'd1,  8'd2}:  e = {5'd6,  16'b000110};
        {8'd5,  8'd1}:  e = {5'd6,  16'b000111};
        {8'd6,  8'd1}:  e = {5'd6,  16'b000101};
        {8'd7,  8'd1}:  e = {5'd6,  16'b000100};
        {8'd0,  8'd4}:  e = {5'd7,  16'b0000110};
        {8'd2,  8'd2}:  e = {5'd7,  16'b0000100};
        {8'd8,  8'd1}:  e = {5'd7,  16'b0000111};
        {8'd9,  8'd1}:  e = {5'd7,  16'b0000101};
        {8'd0,  8'd5}:  e = {5'd8,  16'b00100110};
        {8'd0,  8'd6}:  e = {5'd8,  16'b00100001};
        {8'd1,  8'd3}:  e = {5'd8,  16'b00100101};
        {8'd3,  8'd2}:  e = {5'd8,  16'b00100100};
        {8'd10, 8'd1}:  e = {5'd8,  16'b00100111};
        {8'd11, 8'd1}:  e = {5'd8,  16'b00100011};
        {8'd12, 8'd1}:  e = {5'd8,  16'b00100010};
        {8'd13, 8'd1}:  e = {5'd8,  16'b00100000};
        {8'd0,  8'd7}:  e = {5'd10, 16'b0000001010};
        {8'd1,  8'd4}:  e = {5'd10, 16'b0000001100};
        {8'd2,  8'd3}:  e = {5'd10, 16'b0000001011};
        {8'd4,  8'd2}:  e = {5'd10, 16'b0000001111};
        {8'd5,  8'd2}:  e = {5'd10, 16'b0000001001};
        {8'd14, 8'd1}:  e = {5'd10, 16'b0000001110};
        {8'd15, 8'd1}:  e = {5'd10, 16'b0000001101};
        {8'd16, 8'd1}:  e = {5'd10, 16'b0000001000};
        {8'd0,  8'd8}:  e = {5'd12, 16'b000000011101};
        {8'd0,  8'd9}:  e = {5'd12, 16'b000000011000};
        {8'd0,  8'd10}: e = {5'd12, 16'b000000010011};
        {8'd0,  8'd11}: e = {5'd12, 16'b000000010000};
        {8'd1,  8'd5}:  e = {5'd12, 16'b000000011011};
        {8'd2,  8'd4}:  e = {5'd12, 16'b000000010100};
        {8'd3,  8'd3}:  e = {5'd12, 16'b000000011100};
        {8'd4,  8'd3}:  e = {5'd12, 16'b000000010010};
        {8'd6,  8'd2}:  e = {5'd12, 16'b000000011110};
        {8'd7,  8'd2}:  e = {5'd12, 16'b000000010101};
        {8'd8,  8'd2}:  e = {5'd12, 16'b000000010001};
        {8'd17, 8'd1}:  e = {5'd12, 16'b000000011111};
        {8'd18, 8'd1}:  e = {5'd12, 16'b000000011010};
        {8'd19, 8'd1}:  e = {5'd12, 16'b000000011001};
        {8'd20, 8'd1}:  e = {5'd12, 16'b000000010111};
        {8'd21, 8'd1}:  e = {5'd12, 16'b000000010110};
        {8'd0,  8'd12}: e = {5'd13, 16'b0000000011010};
        {8'd0,  8'd13}: e = {5'd13, 16'b0000000011001};
        {8'd0,  8'd14}: e = {5'd13, 16'b0000000011000};
        {8'd0,  8'd15}: e = {5'd13, 16'b0000000010111};
        {8'd1,  8'd6}:  e = {5'd13, 16'b0000000010110};
        {8'd1,  8'd7}:  e = {5'd13, 16'b0000000010101};
        {8'd2,  8'd5}:  e = {5'd13, 16'b0000000010100};
        {8'd3,  8'd4}:  e = {5'd13, 16'b0000000010011};
        {8'd5,  8'd3}:  e = {5'd13, 16'b0000000010010};
        {8'd9,  8'd2}:  e = {5'd13, 16'b0000000010001};
        {8'd10, 8'd2}:  e = {5'd13, 16'b0000000010000};
        {8'd22, 8'd1}:  e = {5'd13, 16'b0000000011111};
        {8'd23, 8'd1}:  e = {5'd13, 16'b0000000011110};
        {8'd24, 8'd1}:  e = {5'd13, 16'b0000000011101};
        {8'd25, 8'd1}:  e = {5'd13, 16'b0000000011100};
        {8'd26, 8'd1}:  e = {5'd13, 16'b0000000011011};
        {8'd0,  8'd16}: e = {5'd14, 16'b00000000011111};
        {8'd0,  8'd17}: e = {5'd14, 16'b00000000011110};
        {8'd0,  8'd18}: e = {5'd14, 16'b00000000011101};
        {8'd0,  8'd19}: e = {5'd14, 16'b00000000011100};
        {8'd0,  8'd20}: e = {5'd14, 16'b00000000011011};
        {8'd0,  8'd21}: e = {5'd14, 16'b00000000011010};
        {8'd0,  8'd22}: e = {5'd14, 16'b00000000011001};
        {8'd0,  8'd23}: e = {5'd14, 16'b00000000011000};
        {8'd0,  8'd24}: e = {5'd14, 16'b00000000010111};
        {8'd0,  8'd25}: e = {5'd14, 16'b00000000010110};
        {8'd0,  8'd26}: e = {5'd14, 16'b00000000010101};
        {8'd0,  8'd27}: e = {5'd14, 16'b00000000010100};
        {8'd0,  8'd28}: e = {5'd14, 16'b00000000010011};
        {8'd0,  8'd29}: e = {5'd14, 16'b00000000010010};
        {8'd0,  8'd30}: e = {5'd14, 16'b00000000010001};
        {8'd0,  8'd31}: e = {5'd14, 16'b00000000010000};
        {8'd0,  8'd32}: e = {5'd15, 16'b000000000011000};
        {8'd0,  8'd33}: e = {5'd15, 16'b000000000010111};
        {8'd0,  8'd34}: e = {5'd15, 16'b000000000010110};
        {8'd0,  8'd35}: e = {5'd15, 16'b000000000010101};
        {8'd0,  8'd36}: e = {5'd15, 16'b000000000010100};
        {8'd0,  8'd37}: e = {5'd15, 16'b000000000010011};
        {8'd0,  8'd38}: e = {5'd15, 16'b000000000010010};
        {8'd0,  8'd39}: e = {5'd15, 16'b000000000010001};
        {8'd0,  8'd40}: e = {5'd15, 16'b000000000010000};
        {8'd1,  8'd8}:  e = {5'd15, 16'b000000000011111};
        {8'd1,  8'd9}:  e = {5'd15, 16'b000000000011110};
        {8'd1,  8'd10}: e = {5'd15, 16'b000000000011101};
        {8'd1,  8'd11}: e = {5'd15, 16'b000000000011100};
        {8'd1,  8'd12}: e = {5'd15, 16'b000000000011011};
        {8'd1,  8'd13}: e = {5'd15, 16'b000000000011010};
        {8'd1,  8'd14}: e = {5'd15, 16'b000000000011001};
        {8'd1,  8'd15}: e = {5'd16, 16'b0000000000010011};
        {8'd1,  8'd16}: e = {5'd16, 16'b0000000000010010};
        {8'd1,  8'd17}: e = {5'd16, 16'b0000000000010001};
        {8'd1,  8'd18}: e = {5'd16, 16'b0000000000010000};
        {8'd6,  8'd3}:  e = {5'd16, 16'b0000000000010100};
        {8'd11, 8'd2}:  e = {5'd16, 16'b0000000000011010};
        {8'd12, 8'd2}:  e = {5'd16, 16'b0000000000011001};
        {8'd13, 8'd2}:  e = {5'd16, 16'b0000000000011000};
        {8'd14, 8'd2}:  e = {5'd16, 16'b0000000000010111};
        {8'd15, 8'd2}:  e = {5'd16, 16'b0000000000010110};
        {8'd16, 8'd2}:  e = {5'd16, 16'b0000000000010101};
        {8'd27, 8'd1}:  e = {5'd16, 16'b0000000000011111};
        {8'd28, 8'd1}:  e = {5'd16, 16'b0000000000011110};
        {8'd29, 8'd1}:  e = {5'd16, 16'b0000000000011101};
        {8'd30, 8'd1}:  e = {5'd16, 16'b0000000000011100};
        {8'd31, 8'd1}:  e = {5'd16, 16'b0000000000011011};
        default:        e = '0;
      endcase
    end
  end

  always_comb begin
    cw.hit = (e[20:16] != 5'd0);
    if (codetable) begin
      cw.code = {1'b0, e[15:0]};
      cw.len  = e[20:16];
    end else begin
      cw.code = {e[15:0], 1'b0};
      cw.len  = cw.hit ? e[20:16] + 5'd1 : 5'd0;
    end
  end

endmodule

// File: rtl/dct_coeff_huffman_encoder.sv
// Bit-serial MPEG-1 DCT coefficient / address increment VLC encoder, one bit per data_ready beat.
// Define DCT_COEFF_ENCODER_ESCAPE_EN to enable 20/28-bit escape coding of table misses.
module dct_coeff_huffman_encoder
  import mpeg_vlc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_codetable,
  input  logic       in_first,
  input  logic       in_eob,
  input  logic [5:0] in_run,
  input  logic [8:0] in_level,
  output logic       data_valid,
  output logic       data,
  input  logic       data_ready,
  output logic       enc_error
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            neg;
  logic [8:0]      mag;
  logic [15:0]     key;
  vlc_codeword_t   cw;
  logic [SR_W-1:0] load_bits;
  logic [SR_W-1:0] sr_load;
  logic [4:0]      load_len;
  logic            load_err;

  always_comb begin
    neg = in_level[8];
    mag = level_mag(in_level);
    key = in_codetable ? {10'd0, in_level[5:0]} : {2'b00, in_run, mag[7:0]};
  end

  dct_coeff_vlc_table u_table (
    .codetable (in_codetable),
    .key       (key),
    .cw        (cw)
  );

  // Codeword assembled right-aligned, then left-aligned into the shift register.
  always_comb begin
    load_bits = '0;
    load_len  = '0;
    load_err  = 1'b0;
    if (in_codetable) begin
      if (cw.hit) begin
        load_bits = SR_W'(cw.code);
        load_len  = cw.len;
      end else begin
        load_err = 1'b1;
      end
    end else if (in_eob) begin
      if (in_first) begin
        load_err = 1'b1;
      end else begin
        load_bits = SR_W'(EOB_CODE);
        load_len  = 5'(EOB_LEN);
      end
    end else if (mag == 9'd0 || mag > 9'd255) begin
      load_err = 1'b1;
    end else if (in_first && in_run == 6'd0 && mag == 9'd1) begin
      load_bits = SR_W'({1'b1, neg});
      load_len  = 5'd2;
    end else if (cw.hit) begin
      load_bits = SR_W'({cw.code[16:1], neg});
      load_len  = cw.len;
`ifdef DCT_COEFF_ENCODER_ESCAPE_EN
    end else if (mag <= 9'd127) begin
      load_bits = SR_W'({ESC_PREFIX, in_run, in_level[7:0]});
      load_len  = 5'(ESC_SHORT_LEN);
    end else begin
      load_bits = SR_W'({ESC_PREFIX, in_run, (neg ? 8'h80 : 8'h00), in_level[7:0]});
      load_len  = 5'(ESC_LONG_LEN);
    end
`else
    end else begin
      load_err = 1'b1;
    end
`endif
    sr_load = load_bits << (5'(SR_W) - load_len);
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (load_err) begin
            err_d = 1'b1;
          end else begin
            sr_d    = sr_load;
            cnt_d   = load_len;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (data_ready) begin
          sr_d  = sr_q << 1;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Error cycle holds off the next symbol so the pulse is never overlapped.
  assign in_ready   = (state_q == IDLE) && !err_q;
  assign data_valid = (state_q == SHIFT);
  assign data       = sr_q[SR_W-1];
  assign enc_error  = err_q;

endmodule

// File: tb/tb_dct_coeff_huffman_encoder.sv
// Directed-vector bench for dct_coeff_huffman_encoder: bit sequences, timing, stalls, reset.
module tb_dct_coeff_huffman_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_codetable = 1'b0;
  logic       in_first = 1'b0;
  logic       in_eob = 1'b0;
  logic [5:0] in_run = '0;
  logic [8:0] in_level = '0;
  logic       data_valid;
  logic       data;
  logic       data_ready = 1'b1;
  logic       enc_error;

  always #5 clk = ~clk;

  dct_coeff_huffman_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_codetable (in_codetable),
    .in_first     (in_first),
    .in_eob       (in_eob),
    .in_run       (in_run),
    .in_level     (in_level),
    .data_valid   (data_valid),
    .data         (data),
    .data_ready   (data_ready),
    .enc_error    (enc_error)
  );

  typedef struct {
    logic        tbl;
    logic        first;
    logic        eob;
    logic [5:0]  run;
    logic [8:0]  level;
    logic        err;
    int          len;
    logic [27:0] bits;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string what, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", what, idx, got, want);
    end
  endtask

  function automatic vec_t mk(input logic tbl, input logic first, input logic eob, input logic [5:0] run,
                              input logic [8:0] level, input logic err, input int len, input logic [27:0] bits);
    vec_t v;
    v.tbl = tbl; v.first = first; v.eob = eob; v.run = run; v.level = level;
    v.err = err; v.len = len; v.bits = bits;
    return v;
  endfunction

  task automatic run_vec(input int idx, input bit stall);
    vec_t        v;
    logic [27:0] got;
    int          nbits, cyc, err_cyc;
    bit          saw_vld, prev_stall, done;
    logic        prev_dat;
    v = vecs[idx];
    @(negedge clk);
    in_valid = 1'b1; in_codetable = v.tbl; in_first = v.first; in_eob = v.eob;
    in_run = v.run; in_level = v.level; data_ready = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    if (!in_ready) check("accept_timeout", idx, 0, 1);
    @(posedge clk);
    #1;
    // scramble inputs: only the accept-cycle values may matter
    in_valid = 1'b0; in_run = ~v.run; in_level = ~v.level; in_first = ~v.first;
    in_eob = ~v.eob; in_codetable = ~v.tbl;
    got = '0; nbits = 0; cyc = 0; err_cyc = 0; saw_vld = 0; prev_stall = 0; prev_dat = 1'b0; done = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (enc_error && err_cyc == 0) err_cyc = cyc;
      if (prev_stall) check("stall_stable", idx, {30'd0, data_valid, data}, {30'd0, 1'b1, prev_dat});
      if (data_valid) begin
        saw_vld = 1;
        data_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (data_ready) begin
          got = {got[26:0], data};
          nbits++;
        end
        prev_stall = !data_ready;
        prev_dat = data;
      end else begin
        prev_stall = 0;
        if (in_ready) done = 1;
      end
    end
    data_ready = 1'b1;
    check("done_timeout", idx, {31'd0, done}, 1);
    if (v.err) begin
      check("err_pulse_cycle", idx, err_cyc, 1);
      check("err_no_valid", idx, {31'd0, saw_vld}, 0);
      check("err_ready_back", idx, cyc, 2);
    end else begin
      check("no_err", idx, err_cyc, 0);
      check("len", idx, nbits, v.len);
      check("bits", idx, {4'd0, got}, {4'd0, v.bits});
      if (!stall) check("ready_return", idx, cyc, v.len + 1);
    end
  endtask

  initial begin
    vecs.push_back(mk(0, 1, 0, 0, 9'd1,      0, 2,  28'b10));
    vecs.push_back(mk(0, 0, 0, 0, 9'(-1),    0, 3,  28'b111));
    vecs.push_back(mk(0, 0, 0, 1, 9'(-1),    0, 4,  28'b0111));
    vecs.push_back(mk(0, 0, 1, 5, 9'd0,      0, 2,  28'b10));
    vecs.push_back(mk(1, 0, 0, 0, 9'd1,      0, 1,  28'b1));
    vecs.push_back(mk(1, 0, 0, 0, 9'd8,      0, 7,  28'b0000111));
    vecs.push_back(mk(1, 0, 0, 0, 9'd33,     0, 11, 28'b00000011000));
    vecs.push_back(mk(1, 0, 0, 0, 9'd0,      1, 0,  28'b0));
    vecs.push_back(mk(1, 0, 0, 0, 9'd34,     1, 0,  28'b0));
    vecs.push_back(mk(0, 0, 0, 0, 9'd0,      1, 0,  28'b0));
    vecs.push_back(mk(0, 1, 1, 0, 9'd1,      1, 0,  28'b0));
    vecs.push_back(mk(0, 0, 0, 0, 9'(-256),  1, 0,  28'b0));
    vecs.push_back(mk(0, 0, 0, 0, 9'd2,      0, 5,  28'b01000));
    vecs.push_back(mk(0, 0, 0, 2, 9'(-1),    0, 5,  28'b01011));
    vecs.push_back(mk(0, 0, 0, 31, 9'd1,     0, 17, 28'b0000000000011011_0));
    vecs.push_back(mk(0, 0, 0, 0, 9'(-40),   0, 16, 28'b000000000010000_1));
    vecs.push_back(mk(0, 0, 0, 1, 9'd18,     0, 17, 28'b0000000000010000_0));
    vecs.push_back(mk(0, 0, 0, 10, 9'd1,     0, 9,  28'b00100111_0));
    vecs.push_back(mk(0, 0, 0, 0, 9'(-12),   0, 14, 28'b0000000011010_1));
    vecs.push_back(mk(0, 1, 0, 0, 9'(-1),    0, 2,  28'b11));
    vecs.push_back(mk(0, 1, 0, 1, 9'd1,      0, 4,  28'b011_0));
`ifdef DCT_COEFF_ENCODER_ESCAPE_EN
    vecs.push_back(mk(0, 0, 0, 3, 9'd200,    0, 28, 28'b000001_000011_00000000_11001000));
    vecs.push_back(mk(0, 0, 0, 3, 9'(-5),    0, 20, 28'b000001_000011_11111011));
    vecs.push_back(mk(0, 0, 0, 0, 9'(-200),  0, 28, 28'b000001_000000_10000000_00111000));
    vecs.push_back(mk(0, 0, 0, 0, 9'd127,    0, 20, 28'b000001_000000_01111111));
    vecs.push_back(mk(0, 0, 0, 0, 9'(-128),  0, 28, 28'b000001_000000_10000000_10000000));
`else
    vecs.push_back(mk(0, 0, 0, 3, 9'd200,    1, 0,  28'b0));
    vecs.push_back(mk(0, 0, 0, 3, 9'(-5),    1, 0,  28'b0));
    vecs.push_back(mk(0, 0, 0, 0, 9'(-200),  1, 0,  28'b0));
    vecs.push_back(mk(0, 0, 0, 0, 9'd127,    1, 0,  28'b0));
    vecs.push_back(mk(0, 0, 0, 0, 9'(-128),  1, 0,  28'b0));
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", -1, {31'd0, in_ready}, 1);
    check("rst_data_valid", -1, {31'd0, data_valid}, 0);
    check("rst_data", -1, {31'd0, data}, 0);
    check("rst_enc_error", -1, {31'd0, enc_error}, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, 1'b0);

    // same codes under random sink stalls
    for (int r = 0; r < 3; r++) begin
      run_vec(14, 1'b1);
      run_vec(2, 1'b1);
      run_vec(6, 1'b1);
      run_vec(21, 1'b1);
    end

    // reset in the middle of the longest codeword, then recover
    @(negedge clk);
`ifdef DCT_COEFF_ENCODER_ESCAPE_EN
    in_run = 6'd3; in_level = 9'd200;
`else
    in_run = 6'd31; in_level = 9'd1;
`endif
    in_valid = 1'b1; in_codetable = 1'b0; in_first = 1'b0; in_eob = 1'b0; data_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_valid", -2, {31'd0, data_valid}, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", -2, {31'd0, data_valid}, 0);
    check("arst_data", -2, {31'd0, data}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", -2, {31'd0, in_ready}, 1);
    check("post_rst_valid", -2, {31'd0, data_valid}, 0);
    run_vec(2, 1'b0);
    run_vec(6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dct_coeff_huffman_encoder.md
# dct_coeff_huffman_encoder

Bit-serial MPEG-1 variable-length encoder, the transmit-side counterpart of the FMV DCT coefficient / macroblock address increment Huffman decoder. It accepts one symbol per handshake: a run/level pair, an end-of-block, or an address increment. It emits the matching codeword one bit per accepted output beat, MSB first. It is used in the FMV bitstream generator and as a stimulus source for loopback verification of the decoder.

## Interface
- No parameters.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  symbol offered.
- `in_ready`  out  1  symbol accepted when `in_valid && in_ready`.
- `in_codetable`  in  1  0 = DCT coefficient table, 1 = macroblock address increment table (same encoding as the decoder's `codetable`).
- `in_first`  in  1  DCT only: symbol is the first coefficient of a non-intra block (short `1s` form).
- `in_eob`  in  1  DCT only: emit end-of-block; run/level ignored.
- `in_run`  in  6  DCT run, 0..63.
- `in_level`  in  9  signed DCT level, −255..255, nonzero; for `in_codetable=1`, `in_level[5:0]` is the increment, 1..33.
- `data_valid`  out  1  output bit present.
- `data`  out  1  output bit.
- `data_ready`  in  1  sink consumes bit when `data_valid && data_ready`.
- `enc_error`  out  1  one-cycle pulse: accepted symbol was unencodable; no bits emitted.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: `in_ready=1`. On accept, latch the table result into a 28-bit left-aligned shift register and a 5-bit remaining-length counter, then go to SHIFT.
- SHIFT: `data_valid=1`, `data`=shift-register MSB. On each `data_ready`, shift left and decrement. When the last bit is consumed, go to IDLE.
- Codeword construction:
  - DCT with `in_eob`: `10`.
  - DCT with `in_first`, run 0, |level| 1: `1s`.
  - Other DCT table hit: table code, then sign bit `s` (1 = negative).
  - Address increment: table code, no sign bit.
- Escape (DCT only, run/level not in table): `000001`, then run (6 bits), then level:
  - |level| ≤ 127: 8-bit two's complement.
  - 128..255: `00000000` followed by the level byte.
  - −255..−128: `10000000` followed by `level[7:0]`.
  - Total escape length 20 or 28 bits.
- `enc_error` conditions: level 0 without `in_eob`; increment 0 or >33; `|level|` > 255; escape needed while escape is compiled out. Each of these returns to IDLE the next cycle, with `data_valid` never asserted.
- `in_first` with `in_eob` is an error.
- Inputs are sampled only at accept; changes during SHIFT are ignored.

## Timing
- Reset values: `in_ready=1`, `data_valid=0`, `data=0`, `enc_error=0`, FSM = IDLE, counter = 0.
- Accept at cycle N puts the first bit on `data` at N+1.
- With `data_ready` held high, an L-bit code occupies cycles N+1..N+L, and `in_ready` returns at N+L+1. Throughput is L+1 cycles per symbol.
- `data`/`data_valid` are stable while `data_ready=0`; the output is registered, with no combinational path from inputs.
- `enc_error` pulses at N+1; `in_ready` is 1 again at N+2.
- Reset mid-SHIFT: outputs go to their reset values immediately (asynchronous), and the partial codeword is discarded.

## Configuration
- `DCT_COEFF_ENCODER_ESCAPE_EN` defined: escape coding as above.
- Undefined: escape logic is removed, the shift register shrinks to 17 bits, and table misses raise `enc_error`.

## Structure
- Shared package `mpeg_vlc_pkg`:
  - symbol struct (run, level, flags);
  - codeword struct (17-bit code, 5-bit length, hit);
  - escape prefix and EOB constants.
- The decoder's value format `{run[7:0], |level|[7:0]}` is reused as the lookup key.
- Sub-module `dct_coeff_vlc_table`: purely combinational key → {code, length, hit} for both tables. It is the inverse of the decoder trees.
- The top level holds the FSM, shift register and counter.

## Test plan
- DCT run 0, level +1, `in_first=1` → bits `1,0`; then non-first run 0, level −1 → `1,1,1`.
- DCT run 1, level −1 → `0,1,1,1`; `in_eob` → `1,0`, with `in_ready` low for exactly 2 cycles plus 1.
- Address increments 1 → `1`, 8 → `0000111`, 33 → `00000011000`; increment 0 → `enc_error` pulse, no `data_valid`.
- Escape run 3, level 200 → `000001 000011 00000000 11001000` (28 bits); run 3, level −5 → `000001 000011 11111011`. Without the macro, both produce `enc_error`.
- Random `data_ready` stalls: bit sequence unchanged and `data` stable during stalls. Loopback into the decoder returns the original `{run,|level|}` on `result`.
- Assert `reset` in the middle of a 28-bit escape → `data_valid` falls in the same cycle, `in_ready=1` after release, and the next symbol encodes correctly.
